// File: rtl/stack_pkg.sv
// Shared definitions for the stack processor: opcodes and default widths.
package stack_pkg;
    localparam logic [2:0] OP_NOP       = 3'b000;
    localparam logic [2:0] OP_PUSH      = 3'b001;
    localparam logic [2:0] OP_POP       = 3'b010;
    localparam logic [2:0] OP_REPLACE   = 3'b011;
    localparam logic [2:0] OP_POP2_PUSH = 3'b100;
    localparam logic [2:0] OP_DUP       = 3'b101;
    localparam logic [2:0] OP_SWAP      = 3'b110;
    localparam logic [2:0] OP_CLEAR     = 3'b111;

    localparam int DATA_W_DEF = 8;
    localparam int DEPTH_DEF  = 8;
endpackage

// File: rtl/data_stack.sv
// Operand stack: one op per clock, tos/nos read combinationally from state.
// Entry i holds the (i+1)-th oldest value; the top lives at mem[count-1].
module data_stack
    import stack_pkg::*;
#(
    parameter  int DATA_W = DATA_W_DEF,
    parameter  int DEPTH  = DEPTH_DEF,
    localparam int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              op_en,
    input  logic [2:0]        op,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] tos,
    output logic [DATA_W-1:0] nos,
    output logic [CNT_W-1:0]  count,
    output logic              empty,
    output logic              full,
    output logic              overflow,
    output logic              underflow
);
    localparam int IDX_W = $clog2(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              ovf_q, ovf_d;
    logic              unf_q, unf_d;

    logic [CNT_W-1:0]  cnt_m1, cnt_m2;
    logic [IDX_W-1:0]  top_idx, sec_idx, new_idx;
    logic              has1, has2, is_full;

    // Index arithmetic is only used when the guarding has1/has2/is_full allow it,
    // so the wrapped values at count 0/1/DEPTH never reach storage.
    assign cnt_m1  = cnt_q - CNT_W'(1);
    assign cnt_m2  = cnt_q - CNT_W'(2);
    assign top_idx = cnt_m1[IDX_W-1:0];
    assign sec_idx = cnt_m2[IDX_W-1:0];
    assign new_idx = cnt_q[IDX_W-1:0];
    assign has1    = (cnt_q != '0);
    assign has2    = (cnt_q >= CNT_W'(2));
    assign is_full = (cnt_q == CNT_W'(DEPTH));

    assign tos       = has1 ? mem_q[top_idx] : '0;
    assign nos       = has2 ? mem_q[sec_idx] : '0;
    assign count     = cnt_q;
    assign empty     = !has1;
    assign full      = is_full;
    assign overflow  = ovf_q;
    assign underflow = unf_q;

    // Next-state: one case on op; illegal ops only raise a sticky flag.
    always_comb begin
        mem_d = mem_q;
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        unf_d = unf_q;
        if (op_en) begin
            case (op)
                OP_PUSH: begin
                    if (is_full) ovf_d = 1'b1;
                    else begin
                        mem_d[new_idx] = din;
                        cnt_d          = cnt_q + CNT_W'(1);
                    end
                end
                OP_POP: begin
                    if (has1) cnt_d = cnt_m1;
                    else      unf_d = 1'b1;
                end
                OP_REPLACE: begin
                    if (has1) mem_d[top_idx] = din;
                    else      unf_d = 1'b1;
                end
                OP_POP2_PUSH: begin
                    if (has2) begin
                        mem_d[sec_idx] = din;
                        cnt_d          = cnt_m1;
                    end else unf_d = 1'b1;
                end
                OP_DUP: begin
                    if (!has1)        unf_d = 1'b1;
                    else if (is_full) ovf_d = 1'b1;
                    else begin
                        mem_d[new_idx] = mem_q[top_idx];
                        cnt_d          = cnt_q + CNT_W'(1);
                    end
                end
                OP_SWAP: begin
                    if (has2) begin
                        mem_d[top_idx] = mem_q[sec_idx];
                        mem_d[sec_idx] = mem_q[top_idx];
                    end else unf_d = 1'b1;
                end
                OP_CLEAR: cnt_d = '0;
                default: ;
            endcase
        end
    end

    // Count and sticky flags, cleared asynchronously.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    // Entry storage is never cleared; writes are dropped while reset is held.
    always_ff @(posedge clk) begin
        if (reset) mem_q <= mem_d;
    end
endmodule

// File: doc/data_stack.md
Name: data_stack

Overview:
- Hardware operand stack consumed by the control unit and datapath of the 8-bit stack processor.
- It executes one stack operation per clock: PUSH, PUSH_I and PUSH_T all arrive as PUSH with the value already muxed onto din. ALU ops use POP2_PUSH.
- The control unit and ALU read top-of-stack (tos) and next-on-stack (nos) combinationally.
- POP writes tos to RAM, so the RAM write path samples tos in the same cycle as the POP.

Parameters:
- DATA_W, 8, width of each stack entry and of din/tos/nos.
- DEPTH, 8, number of entries; must be ≥ 2. CNT_W = clog2(DEPTH+1), derived locally.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- op_en  input  1  high = execute op this cycle.
- op  input  3  operation code (see package).
- din  input  DATA_W  value for PUSH, REPLACE and POP2_PUSH.
- tos  output  DATA_W  top entry; 0 when empty.
- nos  output  DATA_W  second entry; 0 when count < 2.
- count  output  CNT_W  number of valid entries.
- empty  output  1  count == 0.
- full  output  1  count == DEPTH.
- overflow  output  1  sticky illegal-grow flag.
- underflow  output  1  sticky illegal-shrink flag.

Behaviour:
- Reset, asynchronous while low: count = 0, overflow = 0, underflow = 0, empty = 1, full = 0, tos = 0, nos = 0. Entry storage is not cleared.
- All ops complete in one cycle. Results are visible on tos, nos and count immediately after the rising edge. tos, nos, empty and full are combinational from registered state.
- op_en = 0, or op = NOP: no change.
- PUSH (001): if not full, mem[count] <= din and count + 1. If full: no change, overflow <= 1.
- POP (010): if count ≥ 1, count − 1. The popped value is tos during the POP cycle. If empty: no change, underflow <= 1.
- REPLACE (011): if count ≥ 1, the top entry <= din and count is unchanged. Else underflow <= 1.
- POP2_PUSH (100): for binary ALU ops; din is the result computed from the current tos and nos. If count ≥ 2, mem[count−2] <= din and count − 1. Else no change, underflow <= 1.
- DUP (101):
  - count ≥ 1 and not full: push a copy of tos.
  - empty: underflow <= 1.
  - full: overflow <= 1.
  - In both error cases there is no change.
- SWAP (110): if count ≥ 2, exchange the top two entries. Else underflow <= 1.
- CLEAR (111): count <= 0. Flags are unchanged.
- overflow and underflow stay set until reset. They do not block later legal ops.
- No wrap-around: count saturates at 0 and DEPTH via the rules above.
- Reset asserted mid-op: the op is discarded and reset values apply.

Decomposition:
- Shared package stack_pkg holds:
  - localparams OP_NOP = 3'b000, OP_PUSH = 3'b001, OP_POP = 3'b010, OP_REPLACE = 3'b011, OP_POP2_PUSH = 3'b100, OP_DUP = 3'b101, OP_SWAP = 3'b110, OP_CLEAR = 3'b111;
  - default DATA_W = 8.
- Single module with no sub-module. The entry array and count register live inside it, together with one next-state case on op.

Test Plan:
- Reset low, then release; PUSH din=5 → tos=5, count=1, empty=0, nos=0.
- PUSH 7 → tos=7, nos=5, count=2. POP → during the POP cycle tos=7; afterwards tos=5, count=1. POP → count=0, empty=1, tos=0.
- PUSH 3, PUSH 9, POP2_PUSH din=12 → tos=12, count=1. SWAP → underflow=1, tos=12 unchanged.
- DEPTH PUSHes of 1..8 → full=1, tos=8. A ninth PUSH 0xFF → overflow=1, tos=8, count=8. DUP → overflow stays 1, no change.
- PUSH 4, PUSH 6, SWAP → tos=4, nos=6. DUP → tos=4, nos=4, count=3. REPLACE din=0xAA → tos=0xAA, count=3. CLEAR → count=0; the flags keep their values.
- Assert reset mid-sequence with count=3 and underflow=1 → count=0, underflow=0 immediately (asynchronous). A PUSH with op_en=0 → no change.
